// File: rtl/sparc_exu_alu_wbq.sv
// ALU result write-back queue: E capture, M staging, FIFO to the IRF write port,
// and a combinational bypass lookup over M and every queued entry.
module sparc_exu_alu_wbq #(
  parameter int DATA_W = 64,
  parameter int RD_W   = 5,
  parameter int TID_W  = 2,
  parameter int DEPTH  = 4
) (
  input  logic              rclk,
  input  logic              rst_l,
  input  logic              alu_wbq_vld_e,
  input  logic [DATA_W-1:0] alu_wbq_data_e,
  input  logic [RD_W-1:0]   alu_wbq_rd_e,
  input  logic [TID_W-1:0]  alu_wbq_tid_e,
  input  logic              ecl_wbq_kill_m,
  output logic              wbq_ecl_rdy_e,
  input  logic              irf_wbq_grant_w,
  output logic              wbq_irf_wen_w,
  output logic [DATA_W-1:0] wbq_irf_data_w,
  output logic [RD_W-1:0]   wbq_irf_rd_w,
  output logic [TID_W-1:0]  wbq_irf_tid_w,
  input  logic [RD_W-1:0]   byp_wbq_rs_d,
  input  logic [TID_W-1:0]  byp_wbq_tid_d,
  output logic              wbq_byp_hit_d,
  output logic [DATA_W-1:0] wbq_byp_data_d,
  output logic              wbq_ecl_empty,
  output logic              wbq_ecl_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic              m_vld;
  logic [DATA_W-1:0] m_data;
  logic [RD_W-1:0]   m_rd;
  logic [TID_W-1:0]  m_tid;

  logic [DATA_W-1:0] q_data [DEPTH];
  logic [RD_W-1:0]   q_rd   [DEPTH];
  logic [TID_W-1:0]  q_tid  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              accept;
  logic              push;
  logic              pop;
  logic [CNT_W:0]    occupancy;
  logic [PTR_W-1:0]  idx;

  // Handshakes: E transfers on vld_e & rdy_e at a rclk edge; the IRF write
  // transfers on wen_w & grant_w at a rclk edge. Neither side may retract
  // the other's decision within the cycle; rdy_e never depends on grant_w.
  assign occupancy     = {1'b0, count} + {{CNT_W{1'b0}}, m_vld};
  assign wbq_ecl_rdy_e = occupancy < (CNT_W + 1)'(DEPTH);
  assign accept        = alu_wbq_vld_e & wbq_ecl_rdy_e;
  assign push          = m_vld & ~ecl_wbq_kill_m & (m_rd != '0);
  assign wbq_irf_wen_w = count != '0;
  assign pop           = wbq_irf_wen_w & irf_wbq_grant_w;

  assign wbq_irf_data_w = wbq_irf_wen_w ? q_data[rd_ptr] : '0;
  assign wbq_irf_rd_w   = wbq_irf_wen_w ? q_rd[rd_ptr]   : '0;
  assign wbq_irf_tid_w  = wbq_irf_wen_w ? q_tid[rd_ptr]  : '0;
  assign wbq_ecl_full   = count == CNT_W'(DEPTH);
  assign wbq_ecl_empty  = ~m_vld & (count == '0);

  always_ff @(posedge rclk) begin
    if (!rst_l) begin
      m_vld  <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      m_vld <= accept;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload registers carry no reset; their valids gate every use.
  always_ff @(posedge rclk) begin
    if (accept) begin
      m_data <= alu_wbq_data_e;
      m_rd   <= alu_wbq_rd_e;
      m_tid  <= alu_wbq_tid_e;
    end
    if (push) begin
      q_data[wr_ptr] <= m_data;
      q_rd[wr_ptr]   <= m_rd;
      q_tid[wr_ptr]  <= m_tid;
    end
  end

  // Walk oldest to youngest so a younger match overrides; M wins last.
  always_comb begin
    wbq_byp_hit_d  = 1'b0;
    wbq_byp_data_d = '0;
    idx            = '0;
    if (byp_wbq_rs_d != '0) begin
      for (int k = 0; k < DEPTH; k++) begin
        idx = rd_ptr + PTR_W'(k);
        if ((CNT_W'(k) < count) && (q_rd[idx] == byp_wbq_rs_d) &&
            (q_tid[idx] == byp_wbq_tid_d)) begin
          wbq_byp_hit_d  = 1'b1;
          wbq_byp_data_d = q_data[idx];
        end
      end
      if (m_vld && !ecl_wbq_kill_m && (m_rd == byp_wbq_rs_d) &&
          (m_tid == byp_wbq_tid_d)) begin
        wbq_byp_hit_d  = 1'b1;
        wbq_byp_data_d = m_data;
      end
    end
  end

  a_no_overflow: assert property (@(posedge rclk) disable iff (!rst_l)
    !(push && count == CNT_W'(DEPTH)));
  a_no_underflow: assert property (@(posedge rclk) disable iff (!rst_l)
    !(pop && count == '0));

endmodule
